// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing a single 32-bit barrel shifter.
// Latency: result valid 2 clocks after the accept edge; one operation per 3 cycles.
// Backpressure: result is held in HOLD until out_ready; no new request is accepted meanwhile.

module shift_unit (
    input  logic [31:0] in,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        aorl,
    output logic [31:0] out
);
    always_comb begin
        out = in;
        if (dir)
            out = in << shamt;
        else if (aorl)
            out = $signed(in) >>> shamt;
        else
            out = in >> shamt;
    end
endmodule

module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_dir,
    input  logic        req0_aorl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_dir,
    input  logic        req1_aorl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        out_id
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] op_in_q, op_in_d;
    logic [4:0]  op_shamt_q, op_shamt_d;
    logic        op_dir_q, op_dir_d;
    logic        op_aorl_q, op_aorl_d;
    logic [31:0] out_q, out_d;
    logic        out_id_q, out_id_d;
    logic        grant;
    logic [31:0] shift_res;

    shift_unit u_shift (
        .in    (op_in_q),
        .shamt (op_shamt_q),
        .dir   (op_dir_q),
        .aorl  (op_aorl_q),
        .out   (shift_res)
    );

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_in_d      = op_in_q;
        op_shamt_d   = op_shamt_q;
        op_dir_d     = op_dir_q;
        op_aorl_d    = op_aorl_q;
        out_d        = out_q;
        out_id_d     = out_id_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        out_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready   = ~grant;
                    req1_ready   = grant;
                    last_grant_d = grant;
                    op_in_d      = grant ? req1_in    : req0_in;
                    op_shamt_d   = grant ? req1_shamt : req0_shamt;
                    op_dir_d     = grant ? req1_dir   : req0_dir;
                    op_aorl_d    = grant ? req1_aorl  : req0_aorl;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // last_grant only moves on accept, so it still names this operation's owner.
                out_d    = shift_res;
                out_id_d = last_grant_q;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_in_q      <= '0;
            op_shamt_q   <= '0;
            op_dir_q     <= 1'b0;
            op_aorl_q    <= 1'b0;
            out_q        <= '0;
            out_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_in_q      <= op_in_d;
            op_shamt_q   <= op_shamt_d;
            op_dir_q     <= op_dir_d;
            op_aorl_q    <= op_aorl_d;
            out_q        <= out_d;
            out_id_q     <= out_id_d;
        end
    end

    assign out    = out_q;
    assign out_id = out_id_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with hand-computed results.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_dir, req0_aorl;
    logic [31:0] req0_in;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_dir, req1_aorl;
    logic [31:0] req1_in;
    logic [4:0]  req1_shamt;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_shamt(req0_shamt), .req0_dir(req0_dir), .req0_aorl(req0_aorl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_shamt(req1_shamt), .req1_dir(req1_dir), .req1_aorl(req1_aorl),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_id(out_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One isolated request from requester id with out_ready held high.
    task automatic single_op(input string tag, input logic id, input logic [31:0] a,
                             input logic [4:0] sh, input logic d, input logic m,
                             input logic [31:0] exp);
        out_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_in = a; req1_shamt = sh; req1_dir = d; req1_aorl = m;
        end else begin
            req0_valid = 1'b1; req0_in = a; req0_shamt = sh; req0_dir = d; req0_aorl = m;
        end
        #1;
        check({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_in = 32'hDEAD_BEEF;
        req1_in = 32'hDEAD_BEEF;
        check({tag, "_busy"}, {29'd0, out_valid, req1_ready, req0_ready}, 32'd0);
        tick();
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out"}, out, exp);
        check({tag, "_id"}, {31'd0, out_id}, {31'd0, id});
        tick();
        check({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] held_out;
        logic        exp_g;
        int          grants;

        rst = 1'b1; out_ready = 1'b1;
        req0_valid = 1'b0; req0_in = '0; req0_shamt = '0; req0_dir = 1'b0; req0_aorl = 1'b0;
        req1_valid = 1'b0; req1_in = '0; req1_shamt = '0; req1_dir = 1'b0; req1_aorl = 1'b0;
        do_reset();
        check("rst_state", {30'd0, out_valid, out_id}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);

        single_op("left_r0",   1'b0, 32'd4567, 5'd4, 1'b1, 1'b0, 32'd73072);
        single_op("rl_r1",     1'b1, 32'd4567, 5'd4, 1'b0, 1'b0, 32'd285);
        single_op("ra_r1",     1'b1, 32'd4567, 5'd4, 1'b0, 1'b1, 32'd285);
        single_op("ra_neg",    1'b0, 32'hFFFF_FFC0, 5'd4, 1'b0, 1'b1, 32'hFFFF_FFFC);
        single_op("rl_neg",    1'b0, 32'hFFFF_FFC0, 5'd4, 1'b0, 1'b0, 32'h0FFF_FFFC);
        single_op("sh0",       1'b1, 32'h8000_0001, 5'd0, 1'b0, 1'b1, 32'h8000_0001);
        single_op("left31",    1'b0, 32'h0000_0003, 5'd31, 1'b1, 1'b1, 32'h8000_0000);
        single_op("ra31",      1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF);

        // Continuous contention after reset: grants alternate starting with 0.
        do_reset();
        req0_valid = 1'b1; req0_in = 32'd1; req0_shamt = 5'd1; req0_dir = 1'b1; req0_aorl = 1'b0;
        req1_valid = 1'b1; req1_in = 32'd8; req1_shamt = 5'd1; req1_dir = 1'b0; req1_aorl = 1'b0;
        out_ready = 1'b1;
        exp_g = 1'b0;
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready && req1_ready)
                check("rr_both_rdy", 32'd1, 32'd0);
            if (req0_ready || req1_ready) begin
                check("rr_grant", {31'd0, req1_ready}, {31'd0, exp_g});
                grants++;
            end
            if (out_valid) begin
                check("rr_out_id", {31'd0, out_id}, {31'd0, ~exp_g});
                check("rr_out", out, out_id ? 32'd4 : 32'd2);
            end
            if (req0_ready || req1_ready)
                exp_g = ~exp_g;
            tick();
        end
        check("rr_grants", grants, 32'd4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); tick();

        // Stall in HOLD; a pending req1 must wait until the FSM is back in IDLE.
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_in = 32'h0000_00F0; req0_shamt = 5'd4; req0_dir = 1'b0; req0_aorl = 1'b0;
        #1;
        check("st_rdy0", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_in = 32'd5; req1_shamt = 5'd2; req1_dir = 1'b1; req1_aorl = 1'b0;
        tick();
        held_out = out;
        check("st_hold_out", out, 32'h0000_000F);
        for (int c = 0; c < 5; c++) begin
            check("st_stable", {29'd0, out_valid, out_id, req1_ready | req0_ready}, 32'd4);
            check("st_stable_out", out, held_out);
            req1_in = 32'd5 + 32'(c);
            tick();
        end
        req1_in = 32'd5;
        out_ready = 1'b1;
        #1;
        check("st_exit_rdy", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        check("st_idle_vld", {31'd0, out_valid}, 32'd0);
        check("st_idle_rdy1", {30'd0, req1_ready, req0_ready}, 32'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        check("st_r1_out", out, 32'd20);
        check("st_r1_id", {31'd0, out_id}, 32'd1);
        tick();

        // Reset while BUSY: result dropped, last_grant restored.
        req0_valid = 1'b1; req0_in = 32'd9; req0_shamt = 5'd1; req0_dir = 1'b1; req0_aorl = 1'b0;
        #1;
        check("rb_rdy0", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rb_no_vld", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("rb_out_clr", out, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rb_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Clock and reset SHALL be: clk, one clock for all state; rst, synchronous, active-high.
REQ-002 Ports SHALL be, clock and reset first:
 clk  in  1  clock, rising edge.
 rst  in  1  synchronous reset, active-high.
 req0_valid  in  1  requester 0 has a shift operation pending.
 req0_ready  out  1  requester 0 operation accepted this cycle.
 req0_in  in  32  requester 0 operand.
 req0_shamt  in  5  requester 0 shift amount, 0..31.
 req0_dir  in  1  requester 0 direction: 1 = left, 0 = right.
 req0_aorl  in  1  requester 0 mode: 1 = arithmetic, 0 = logical.
 req1_valid, req1_ready, req1_in, req1_shamt, req1_dir, req1_aorl  same widths and meanings, requester 1.
 out_valid  out  1  result held on out.
 out_ready  in  1  consumer takes the result.
 out  out  32  shift result.
 out_id  out  1  requester that owns the result.

Function
REQ-003 All shifting SHALL use one shared 32-bit shifter datapath with ports in, shamt, dir, aorl and out; it SHALL not be duplicated.
REQ-004 Shift semantics: left SHALL zero-fill for both modes; right logical SHALL zero-fill; right arithmetic SHALL replicate bit 31; shamt 0 SHALL pass the operand through unchanged.
REQ-005 The FSM SHALL have states IDLE, BUSY and HOLD, encoded in 2 bits; the unused encoding SHALL go to IDLE on the next clock.
REQ-006 IDLE: if any reqN_valid is high, the block SHALL pick a grant, raise that reqN_ready for that cycle only, latch that requester's in, shamt, dir and aorl into operand registers, and go to BUSY. Otherwise it SHALL stay in IDLE.
REQ-007 BUSY (one cycle): the shifter SHALL take the latched operands; its output SHALL load the out register, out_id SHALL load, and the FSM SHALL go to HOLD.
REQ-008 HOLD: out_valid SHALL be 1, and out and out_id SHALL stay stable. When out_ready is 1, the FSM SHALL go to IDLE at that edge.
REQ-009 Latency: out_valid SHALL rise 2 clocks after the accept edge (accept edge, then BUSY edge). Throughput SHALL be one operation per 3 cycles when out_ready is held high.
REQ-010 Arbitration SHALL be round-robin with a 1-bit last_grant register:
 - only one requester valid: that requester is granted;
 - both valid: the requester that is not last_grant is granted;
 - last_grant SHALL update only on an accept.
REQ-011 reqN_ready SHALL be 0 in BUSY and HOLD, and SHALL never be 1 for both requesters in the same cycle.
REQ-012 A requester SHALL be allowed to hold reqN_valid with changing operands while not granted; only values present on the accept cycle SHALL be used.
REQ-013 out_valid SHALL be 0 in IDLE and BUSY. out and out_id SHALL keep their last values outside HOLD.
REQ-014 A request that arrives in the cycle HOLD exits SHALL not be accepted until the next cycle, when the FSM is in IDLE.

Reset
REQ-015 While rst is 1 at a clock edge, the block SHALL set: state = IDLE, last_grant = 1 (so requester 0 wins the first contention), out = 0, out_id = 0, out_valid = 0, req0_ready = 0, req1_ready = 0, operand registers = 0.
REQ-016 Reset asserted in BUSY or HOLD SHALL drop the in-flight result with no out_valid pulse. The first accept after reset release SHALL follow REQ-010 with last_grant = 1.

Verification
REQ-017 Req0 only, in = 4567, shamt = 4, dir = 1, aorl = 0, out_ready = 1 -> req0_ready one cycle, out_valid 2 cycles later, out = 73072, out_id = 0.
REQ-018 Req1 only, in = 4567, shamt = 4, dir = 0, aorl = 0 or 1 -> out = 285, out_id = 1.
REQ-019 Req0 only, in = -64 (0xFFFFFFC0), shamt = 4, dir = 0:
 - aorl = 1 -> out = 0xFFFFFFFC;
 - aorl = 0 -> out = 0x0FFFFFFC.
REQ-020 Both requesters held valid continuously after reset, out_ready = 1 -> grants alternate 0,1,0,1; out_id sequence 0,1,0,1; never two readys in one cycle.
REQ-021 out_ready = 0 for 5 cycles in HOLD -> out_valid, out and out_id stay stable and no reqN_ready is raised; out_ready = 1 -> IDLE next cycle.
REQ-022 rst pulsed in BUSY -> no out_valid; then both requesters valid -> requester 0 granted first.
